// File: rtl/wb_spm_host_master_if.sv
// Command/response stream plus Wishbone pipelined bus bundle for wb_spm_host_master.
// master: the host-master block. slave: the command source, response sink and bus slave.
interface wb_spm_host_master_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  logic              o_wb_cyc;
  logic              o_wb_stb;
  logic              o_wb_we;
  logic [ADDR_W-1:0] o_wb_addr;
  logic [DATA_W-1:0] o_wb_data;
  logic              i_wb_ack;
  logic              i_wb_stall;
  logic [DATA_W-1:0] i_wb_data;

  modport master (
    input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready,
    input  i_wb_ack, i_wb_stall, i_wb_data,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready,
    output i_wb_ack, i_wb_stall, i_wb_data,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data
  );
endinterface

// File: rtl/wb_spm_host_master.sv
// Single-outstanding Wishbone pipelined master: one bus transaction per command,
// with stall-aware request phase, ack-timeout watchdog and back-pressured response.
module wb_spm_host_master #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  wb_spm_host_master_if.master  bus
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              cyc_q, cyc_d;
  logic              stb_q, stb_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cmd_ready_q <= 1'b1;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_ready_q <= cmd_ready_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cmd_ready_d = cmd_ready_q;
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    we_d        = we_q;
    addr_d      = addr_q;
    data_d      = data_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          we_d        = bus.cmd_we;
          addr_d      = bus.cmd_addr;
          data_d      = bus.cmd_wdata;
          cyc_d       = 1'b1;
          stb_d       = 1'b1;
          cnt_d       = '0;
          cmd_ready_d = 1'b0;
          state_d     = REQ;
        end
      end

      REQ, WAIT: begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
        if (state_q == REQ && !bus.i_wb_stall) begin
          stb_d   = 1'b0;
          state_d = WAIT;
        end
        // An ack on the same edge as the timeout still completes normally
        if (bus.i_wb_ack) begin
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = we_q ? '0 : bus.i_wb_data;
          state_d     = RESP;
        end else if (cnt_q == CNT_LAST) begin
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
          state_d     = RESP;
        end
      end

      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.o_wb_cyc  = cyc_q;
  assign bus.o_wb_stb  = stb_q;
  assign bus.o_wb_we   = we_q;
  assign bus.o_wb_addr = addr_q;
  assign bus.o_wb_data = data_q;

endmodule

// File: tb/tb_wb_spm_host_master.sv
// Directed bench for wb_spm_host_master: default-timeout instance with a small slave
// model, plus a TIMEOUT_CYCLES=4 instance driven by hand for ack/timeout coincidence.
module tb_wb_spm_host_master;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int vec  = 0;
  int errs = 0;

  wb_spm_host_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  wb_spm_host_master_if #(.ADDR_W(32), .DATA_W(32)) bus2 ();

  wb_spm_host_master #(.TIMEOUT_CYCLES(16), .ADDR_W(32), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  wb_spm_host_master #(.TIMEOUT_CYCLES(4), .ADDR_W(32), .DATA_W(32)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  // Slave model: stalls stall_req cycles per request, then acks one cycle later if ack_en
  int          stall_req  = 0;
  int          stall_done = 0;
  int          accept_cnt = 0;
  bit          ack_en     = 1'b1;
  logic        inj_ack    = 1'b0;
  logic        slave_ack  = 1'b0;
  logic [31:0] rd_value   = 32'h0;
  logic [31:0] slave_data = 32'h0;

  assign bus.i_wb_stall = bus.o_wb_stb && (stall_done < stall_req);
  assign bus.i_wb_ack   = slave_ack | inj_ack;
  assign bus.i_wb_data  = inj_ack ? 32'hBAD0_BAD0 : slave_data;

  always @(posedge clk) begin
    slave_ack <= 1'b0;
    if (rst || !bus.o_wb_cyc) begin
      stall_done <= 0;
    end else if (bus.o_wb_stb) begin
      if (stall_done < stall_req) begin
        stall_done <= stall_done + 1;
      end else begin
        accept_cnt <= accept_cnt + 1;
        if (ack_en) begin
          slave_ack  <= 1'b1;
          slave_data <= rd_value;
        end
      end
    end
  end

  // Issue one command from a negedge with cmd_ready high; follow it until rsp_valid.
  // lat counts edges from acceptance to the edge that raised rsp_valid.
  task automatic run_cmd(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input int budget, output int lat, output int stb_n,
                         output int cyc_n, output bit got, output bit stable);
    lat = 0; stb_n = 0; cyc_n = 0; got = 1'b0; stable = 1'b1;
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = we;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.cmd_we    = ~we;
    bus.cmd_addr  = ~addr;
    bus.cmd_wdata = ~wdata;
    @(negedge clk);
    for (int i = 1; i <= budget; i++) begin
      if (bus.o_wb_stb === 1'b1) begin
        stb_n++;
        if (bus.o_wb_we !== we || bus.o_wb_addr !== addr || bus.o_wb_data !== wdata) stable = 1'b0;
      end
      if (bus.o_wb_cyc === 1'b1) cyc_n++;
      if (bus.rsp_valid === 1'b1) begin
        got = 1'b1;
        lat = i - 1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vec++;
    if (bus.cmd_ready !== 1'b1) begin
      errs++; $display("FAIL reset_cmd_ready got=%b exp=1", bus.cmd_ready);
    end
    vec++;
    if ({bus.rsp_valid, bus.rsp_err, bus.o_wb_cyc, bus.o_wb_stb, bus.o_wb_we} !== 5'b0) begin
      errs++; $display("FAIL reset_flags got=%b exp=00000",
                       {bus.rsp_valid, bus.rsp_err, bus.o_wb_cyc, bus.o_wb_stb, bus.o_wb_we});
    end
    vec++;
    if (bus.o_wb_addr !== 32'h0 || bus.o_wb_data !== 32'h0 || bus.rsp_rdata !== 32'h0) begin
      errs++; $display("FAIL reset_data addr=%h data=%h rdata=%h exp=0", bus.o_wb_addr,
                       bus.o_wb_data, bus.rsp_rdata);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    int lat, stb_n, cyc_n, acc0;
    bit got, stable;
    acc0 = accept_cnt;
    run_cmd(1'b1, 32'h3000_0000, 32'h0000_A512, 40, lat, stb_n, cyc_n, got, stable);
    vec++;
    if (!got || lat != 2 || stb_n != 1 || !stable) begin
      errs++; $display("FAIL write_txn got=%0b lat=%0d stb=%0d stable=%0b exp 1/2/1/1",
                       got, lat, stb_n, stable);
    end
    vec++;
    if (bus.rsp_err !== 1'b0 || bus.rsp_rdata !== 32'h0 || accept_cnt != acc0 + 1) begin
      errs++; $display("FAIL write_rsp err=%b rdata=%h accepts=%0d exp 0/0/1", bus.rsp_err,
                       bus.rsp_rdata, accept_cnt - acc0);
    end
    @(negedge clk);
    vec++;
    if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      errs++; $display("FAIL write_handshake rsp_valid=%b cmd_ready=%b exp 0/1",
                       bus.rsp_valid, bus.cmd_ready);
    end
    vec++;
    if (bus.o_wb_we !== 1'b1 || bus.o_wb_data !== 32'h0000_A512 || bus.o_wb_addr !== 32'h3000_0000) begin
      errs++; $display("FAIL write_hold we=%b data=%h addr=%h exp 1/0000a512/30000000",
                       bus.o_wb_we, bus.o_wb_data, bus.o_wb_addr);
    end
    rd_value = 32'h0000_12A5;
    run_cmd(1'b0, 32'h3000_0000, 32'h0, 40, lat, stb_n, cyc_n, got, stable);
    vec++;
    if (!got || lat != 2 || stb_n != 1 || !stable) begin
      errs++; $display("FAIL read_txn got=%0b lat=%0d stb=%0d stable=%0b exp 1/2/1/1",
                       got, lat, stb_n, stable);
    end
    vec++;
    if (bus.rsp_rdata !== 32'h0000_12A5 || bus.rsp_err !== 1'b0) begin
      errs++; $display("FAIL read_rsp rdata=%h err=%b exp 000012a5/0", bus.rsp_rdata, bus.rsp_err);
    end
    @(negedge clk);
  endtask

  task automatic test_stall();
    int lat, stb_n, cyc_n, acc0;
    bit got, stable;
    acc0 = accept_cnt;
    stall_req = 3;
    run_cmd(1'b1, 32'h3000_0004, 32'h5A5A_0F0F, 40, lat, stb_n, cyc_n, got, stable);
    vec++;
    if (!got || stb_n != 4 || !stable || lat != 5) begin
      errs++; $display("FAIL stall_txn got=%0b stb=%0d stable=%0b lat=%0d exp 1/4/1/5",
                       got, stb_n, stable, lat);
    end
    vec++;
    if (accept_cnt != acc0 + 1 || bus.rsp_err !== 1'b0 || bus.rsp_rdata !== 32'h0) begin
      errs++; $display("FAIL stall_rsp accepts=%0d err=%b rdata=%h exp 1/0/0",
                       accept_cnt - acc0, bus.rsp_err, bus.rsp_rdata);
    end
    stall_req = 0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int lat, stb_n, cyc_n;
    bit got, stable;
    ack_en = 1'b0;
    run_cmd(1'b0, 32'h3000_0010, 32'h0, 40, lat, stb_n, cyc_n, got, stable);
    vec++;
    if (!got || cyc_n != 16 || lat != 16 || stb_n != 1) begin
      errs++; $display("FAIL timeout_txn got=%0b cyc=%0d lat=%0d stb=%0d exp 1/16/16/1",
                       got, cyc_n, lat, stb_n);
    end
    vec++;
    if (bus.rsp_err !== 1'b1 || bus.rsp_rdata !== 32'h0 || bus.o_wb_cyc !== 1'b0) begin
      errs++; $display("FAIL timeout_rsp err=%b rdata=%h cyc=%b exp 1/0/0", bus.rsp_err,
                       bus.rsp_rdata, bus.o_wb_cyc);
    end
    repeat (3) @(negedge clk);
    inj_ack = 1'b1;
    @(negedge clk);
    inj_ack = 1'b0;
    vec++;
    if (bus.rsp_valid !== 1'b0 || bus.o_wb_cyc !== 1'b0 || bus.cmd_ready !== 1'b1 ||
        bus.rsp_rdata !== 32'h0) begin
      errs++; $display("FAIL late_ack rsp_valid=%b cyc=%b cmd_ready=%b rdata=%h exp 0/0/1/0",
                       bus.rsp_valid, bus.o_wb_cyc, bus.cmd_ready, bus.rsp_rdata);
    end
    ack_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int lat, stb_n, cyc_n;
    bit got, stable;
    bus.rsp_ready = 1'b0;
    rd_value = 32'hC0DE_0042;
    run_cmd(1'b0, 32'h3000_0004, 32'h0, 40, lat, stb_n, cyc_n, got, stable);
    vec++;
    if (!got || lat != 2) begin
      errs++; $display("FAIL bp_txn got=%0b lat=%0d exp 1/2", got, lat);
    end
    // A pending command must wait out the response, including its handshake edge
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = 1'b1;
    bus.cmd_addr  = 32'h3000_0000;
    bus.cmd_wdata = 32'h1111_2222;
    for (int c = 1; c <= 5; c++) begin
      vec++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'hC0DE_0042 || bus.rsp_err !== 1'b0 ||
          bus.cmd_ready !== 1'b0 || bus.o_wb_cyc !== 1'b0) begin
        errs++; $display("FAIL bp_hold cycle=%0d valid=%b rdata=%h err=%b cmd_ready=%b cyc=%b exp 1/c0de0042/0/0/0",
                         c, bus.rsp_valid, bus.rsp_rdata, bus.rsp_err, bus.cmd_ready, bus.o_wb_cyc);
      end
      inj_ack = (c == 2);
      @(negedge clk);
    end
    inj_ack = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    vec++;
    if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.o_wb_cyc !== 1'b0) begin
      errs++; $display("FAIL bp_release valid=%b cmd_ready=%b cyc=%b exp 0/1/0",
                       bus.rsp_valid, bus.cmd_ready, bus.o_wb_cyc);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int lat, stb_n, cyc_n;
    bit got, stable;
    ack_en = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = 1'b0;
    bus.cmd_addr  = 32'h3000_0004;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    vec++;
    if (bus.o_wb_cyc !== 1'b1 || bus.o_wb_stb !== 1'b0) begin
      errs++; $display("FAIL mid_wait cyc=%b stb=%b exp 1/0", bus.o_wb_cyc, bus.o_wb_stb);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vec++;
    if (bus.o_wb_cyc !== 1'b0 || bus.o_wb_stb !== 1'b0 || bus.rsp_valid !== 1'b0 ||
        bus.cmd_ready !== 1'b1) begin
      errs++; $display("FAIL mid_reset cyc=%b stb=%b rsp_valid=%b cmd_ready=%b exp 0/0/0/1",
                       bus.o_wb_cyc, bus.o_wb_stb, bus.rsp_valid, bus.cmd_ready);
    end
    inj_ack = 1'b1;
    @(negedge clk);
    inj_ack = 1'b0;
    @(negedge clk);
    vec++;
    if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
      errs++; $display("FAIL mid_stray_ack rsp_valid=%b cmd_ready=%b exp 0/1",
                       bus.rsp_valid, bus.cmd_ready);
    end
    ack_en = 1'b1;
    rd_value = 32'h0000_7777;
    run_cmd(1'b0, 32'h3000_0004, 32'h0, 40, lat, stb_n, cyc_n, got, stable);
    vec++;
    if (!got || lat != 2 || bus.rsp_rdata !== 32'h0000_7777 || bus.rsp_err !== 1'b0) begin
      errs++; $display("FAIL mid_recover got=%0b lat=%0d rdata=%h err=%b exp 1/2/00007777/0",
                       got, lat, bus.rsp_rdata, bus.rsp_err);
    end
    @(negedge clk);
  endtask

  task automatic test_ack_timeout_coincide();
    int cyc_n, lat;
    bit got;
    // Plain timeout on the short instance
    cyc_n = 0; lat = 0; got = 1'b0;
    bus2.cmd_valid = 1'b1;
    @(posedge clk);
    #1 bus2.cmd_valid = 1'b0;
    @(negedge clk);
    for (int i = 1; i <= 20; i++) begin
      if (bus2.o_wb_cyc === 1'b1) cyc_n++;
      if (bus2.rsp_valid === 1'b1) begin
        got = 1'b1; lat = i - 1; break;
      end
      @(negedge clk);
    end
    vec++;
    if (!got || cyc_n != 4 || lat != 4 || bus2.rsp_err !== 1'b1 || bus2.rsp_rdata !== 32'h0) begin
      errs++; $display("FAIL t4_timeout got=%0b cyc=%0d lat=%0d err=%b rdata=%h exp 1/4/4/1/0",
                       got, cyc_n, lat, bus2.rsp_err, bus2.rsp_rdata);
    end
    @(negedge clk);
    // Ack sampled on the 4th counted edge, while still stalled in the request phase
    bus2.cmd_valid = 1'b1;
    @(posedge clk);
    #1 bus2.cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    bus2.i_wb_ack  = 1'b1;
    bus2.i_wb_data = 32'h1234_5678;
    @(negedge clk);
    bus2.i_wb_ack  = 1'b0;
    bus2.i_wb_data = 32'h0;
    vec++;
    if (bus2.rsp_valid !== 1'b1 || bus2.rsp_err !== 1'b0 || bus2.rsp_rdata !== 32'h1234_5678) begin
      errs++; $display("FAIL t4_coincide valid=%b err=%b rdata=%h exp 1/0/12345678",
                       bus2.rsp_valid, bus2.rsp_err, bus2.rsp_rdata);
    end
    @(negedge clk);
  endtask

  initial begin
    bus.cmd_valid  = 1'b0;
    bus.cmd_we     = 1'b0;
    bus.cmd_addr   = 32'h0;
    bus.cmd_wdata  = 32'h0;
    bus.rsp_ready  = 1'b1;
    bus2.cmd_valid = 1'b0;
    bus2.cmd_we    = 1'b0;
    bus2.cmd_addr  = 32'h3000_0000;
    bus2.cmd_wdata = 32'h0;
    bus2.rsp_ready = 1'b1;
    bus2.i_wb_ack  = 1'b0;
    bus2.i_wb_stall = 1'b1;
    bus2.i_wb_data = 32'h0;

    test_reset();
    test_write_read();
    test_stall();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    test_ack_timeout_coincide();

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/wb_spm_host_master.md
Name: wb_spm_host_master

Overview:
- Single-outstanding Wishbone pipelined master.
- Turns a valid/ready command stream into one Wishbone bus transaction per command and returns a response: read data, or a timeout error.
- Used by test harnesses and management logic to drive the SPM processor's Wishbone slave: address/data loads to the input register at base+0, status reads from base+4.
- Includes a stall-aware request phase, an ack-timeout watchdog and a back-pressured response port.

Parameters:
TIMEOUT_CYCLES, 16, cycles allowed from first stb cycle to ack before an error response; legal range 2..255
ADDR_W, 32, Wishbone address width
DATA_W, 32, Wishbone data width

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
cmd_valid  input  1  command offered
cmd_ready  output  1  master can accept a command
cmd_we  input  1  1 = write, 0 = read
cmd_addr  input  ADDR_W  target byte address
cmd_wdata  input  DATA_W  write data, ignored for reads
rsp_valid  output  1  response available
rsp_ready  input  1  consumer takes the response
rsp_rdata  output  DATA_W  read data; 0 for writes and for errors
rsp_err  output  1  1 = timeout, no ack received
o_wb_cyc  output  1  bus cycle active
o_wb_stb  output  1  request strobe
o_wb_we  output  1  write enable
o_wb_addr  output  ADDR_W  address
o_wb_data  output  DATA_W  write data
i_wb_ack  input  1  slave completion
i_wb_stall  input  1  slave cannot accept the request
i_wb_data  input  DATA_W  slave read data

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: state IDLE; cmd_ready=1. All other outputs are 0: rsp_valid, rsp_rdata, rsp_err, o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data. Timeout counter = 0.
- All outputs are registered.
- cmd_ready is 1 only in IDLE.
- States: IDLE, REQ, WAIT, RESP.
- IDLE:
  - cmd_valid & cmd_ready at edge T latches we/addr/wdata into o_wb_we/o_wb_addr/o_wb_data.
  - Next state REQ. o_wb_cyc=o_wb_stb=1 from T+1. Counter cleared.
- REQ:
  - cyc=stb=1; we/addr/data held stable.
  - At each edge with i_wb_stall=0 the request is accepted: stb deasserts next cycle and the state moves to WAIT, unless ack arrives in the same cycle (see completion).
  - i_wb_stall=1 keeps the master in REQ.
- WAIT:
  - cyc=1, stb=0.
  - i_wb_ack=1 at an edge completes the transaction.
- Counter:
  - Increments every cycle spent in REQ or WAIT.
  - On reaching TIMEOUT_CYCLES without an ack: cyc=stb=0, rsp_err=1, rsp_rdata=0, state RESP.
  - Width is clog2(TIMEOUT_CYCLES+1); it never wraps.
- Completion:
  - On the ack edge (in REQ or WAIT): cyc=stb=0 next cycle; rsp_valid=1; rsp_err=0.
  - rsp_rdata = i_wb_data sampled on the ack edge for reads, 0 for writes.
  - Ack and timeout on the same edge: ack wins.
- RESP:
  - rsp_valid/rsp_rdata/rsp_err held stable until rsp_valid & rsp_ready at an edge.
  - Then rsp_valid=0, state IDLE, cmd_ready=1 next cycle.
  - No new command is accepted in the same cycle as the response handshake.
- Latency, zero-stall slave that acks one cycle after stb:
  - cmd accepted at edge T; stb high in cycle T+1.
  - ack sampled at edge T+2; rsp_valid high from T+2 (visible in cycle T+2→T+3).
  - With rsp_ready=1, the next command can be accepted at edge T+4.
- Stray acks: i_wb_ack in IDLE or RESP, including a late ack after a timeout, is ignored. It alters no output.
- Reset mid-transaction: at the rst edge, cyc/stb drop to 0 and any pending response is discarded.
- o_wb_data and o_wb_we keep their last values after the cycle ends; slaves must qualify them with cyc/stb.
- Exactly one transaction is outstanding at a time; o_wb_stb is never high while o_wb_cyc is low.

Test Plan:
- Write then read, slave at base 0x3000_0000:
  - cmd write addr 0x3000_0000 data 0x0000_A512 -> one stb cycle with we=1 and that addr/data; rsp_err=0, rsp_rdata=0.
  - cmd read addr 0x3000_0000 -> rsp_rdata=0x0000_12A5, rsp_err=0.
  - Read latency: rsp_valid asserts 2 edges after cmd acceptance.
- Stall: slave model holds i_wb_stall=1 for 3 cycles on a write to 0x3000_0004 -> stb high 4 cycles, addr/data/we constant throughout, exactly one acceptance, one response.
- Timeout: read of unmapped 0x3000_0010 (slave never acks) -> cyc high exactly 16 cycles, then rsp_valid=1 with rsp_err=1, rsp_rdata=0; an ack injected 3 cycles later is ignored.
- Response back-pressure: rsp_ready=0 for 5 cycles after a read completes -> rsp fields stable, cmd_ready=0, cyc=0 throughout; handshake on cycle 6 -> cmd_ready=1 next cycle.
- Reset mid-transaction: assert rst for 1 cycle while in WAIT -> cyc/stb/rsp_valid=0 and cmd_ready=1 after that edge; a following ack produces no response; a new read afterwards completes normally.
- Ack/timeout coincidence: TIMEOUT_CYCLES=4, slave acks on the 4th counted cycle -> rsp_err=0 with valid read data.
